// File: rtl/regfile_write_port_ctrl.sv
// Write-port owner for the single-write-port register file: arbitrates ALU/load writeback through a small queue and stalls issue on RAW/WAW hazards.
// Optional operand forwarding from the registered write port is enabled by defining RF_FORWARD_EN.
module regfile_write_port_ctrl_chk #(
    parameter int CNT_W     = 3,
    parameter int BUF_DEPTH = 4
) (
    input logic             clk_i,
    input logic             reset_i,
    input logic             alu_valid_i,
    input logic [CNT_W-1:0] count_i
);
    // ALU has no backpressure, so it must only fire while two queue slots are free
    a_alu_headroom: assert property (@(posedge clk_i) disable iff (reset_i)
        alu_valid_i |-> (count_i <= CNT_W'(BUF_DEPTH - 2)));

    a_no_overflow: assert property (@(posedge clk_i) disable iff (reset_i)
        count_i <= CNT_W'(BUF_DEPTH));
endmodule

module regfile_write_port_ctrl #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int BUF_DEPTH = 4
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_rd,
    input  logic [ADDR_W-1:0] issue_rs1,
    input  logic [ADDR_W-1:0] issue_rs2,
    output logic              issue_ready,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              mem_valid,
    input  logic [ADDR_W-1:0] mem_rd,
    input  logic [DATA_W-1:0] mem_data,
    output logic              mem_ready,
    output logic              WE,
    output logic [ADDR_W-1:0] AD3,
    output logic [DATA_W-1:0] WD3
`ifdef RF_FORWARD_EN
    ,
    output logic              fwd1_hit,
    output logic [DATA_W-1:0] fwd1_data,
    output logic              fwd2_hit,
    output logic [DATA_W-1:0] fwd2_data
`endif
);
    localparam int NREG  = 2 ** ADDR_W;
    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic              we_q, we_d;
    logic [ADDR_W-1:0] ad3_q, ad3_d;
    logic [DATA_W-1:0] wd3_q, wd3_d;
    logic [NREG-1:0]   pending_q, pending_d;

    logic [ADDR_W-1:0] q_rd_q   [BUF_DEPTH];
    logic [DATA_W-1:0] q_data_q [BUF_DEPTH];
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic              head_valid_s, alu_cand_s, mem_cand_s;
    logic              alu_enq_s, mem_enq_s, deq_s;
    logic [PTR_W-1:0]  mem_slot_s;
    logic              room_s, issue_fire_s;
    logic              fwd1_hit_s, fwd2_hit_s;

    assign room_s       = (count_q <= CNT_W'(BUF_DEPTH - 2));
    assign mem_ready    = room_s;
    assign head_valid_s = (count_q != '0);
    assign alu_cand_s   = alu_valid && (alu_rd != '0);
    assign mem_cand_s   = mem_valid && room_s && (mem_rd != '0);
    assign issue_fire_s = issue_valid && issue_ready;

`ifdef RF_FORWARD_EN
    assign fwd1_hit_s = we_q && (ad3_q == issue_rs1) && (issue_rs1 != '0);
    assign fwd2_hit_s = we_q && (ad3_q == issue_rs2) && (issue_rs2 != '0);
    assign fwd1_hit   = fwd1_hit_s;
    assign fwd2_hit   = fwd2_hit_s;
    assign fwd1_data  = wd3_q;
    assign fwd2_data  = wd3_q;
`else
    assign fwd1_hit_s = 1'b0;
    assign fwd2_hit_s = 1'b0;
`endif

    // Issue gate: a forwarded source operand no longer waits on its pending bit
    always_comb begin
        issue_ready = !(pending_q[issue_rs1] && !fwd1_hit_s)
                   && !(pending_q[issue_rs2] && !fwd2_hit_s)
                   && !pending_q[issue_rd]
                   && room_s;
    end

    // Arbitration: queue head beats ALU beats load; losers go to the queue, ALU first
    always_comb begin
        we_d      = 1'b0;
        ad3_d     = ad3_q;
        wd3_d     = wd3_q;
        deq_s     = 1'b0;
        alu_enq_s = 1'b0;
        mem_enq_s = 1'b0;
        if (head_valid_s) begin
            we_d      = 1'b1;
            ad3_d     = q_rd_q[head_q];
            wd3_d     = q_data_q[head_q];
            deq_s     = 1'b1;
            alu_enq_s = alu_cand_s;
            mem_enq_s = mem_cand_s;
        end else if (alu_cand_s) begin
            we_d      = 1'b1;
            ad3_d     = alu_rd;
            wd3_d     = alu_data;
            mem_enq_s = mem_cand_s;
        end else if (mem_cand_s) begin
            we_d  = 1'b1;
            ad3_d = mem_rd;
            wd3_d = mem_data;
        end else begin
            we_d = 1'b0;
        end
    end

    // Queue pointer and occupancy bookkeeping
    always_comb begin
        mem_slot_s = tail_q + PTR_W'(alu_enq_s);
        tail_d     = tail_q + PTR_W'(alu_enq_s) + PTR_W'(mem_enq_s);
        head_d     = head_q + PTR_W'(deq_s);
        count_d    = count_q + CNT_W'(alu_enq_s) + CNT_W'(mem_enq_s) - CNT_W'(deq_s);
    end

    // Scoreboard: a new issue to the same register outranks the retiring write
    always_comb begin
        pending_d = pending_q;
        if (we_q) begin
            pending_d[ad3_q] = 1'b0;
        end else begin
            pending_d[ad3_q] = pending_q[ad3_q];
        end
        if (issue_fire_s && (issue_rd != '0)) begin
            pending_d[issue_rd] = 1'b1;
        end else begin
            pending_d[issue_rd] = pending_d[issue_rd];
        end
        pending_d[0] = 1'b0;
    end

    // Write port, scoreboard and queue control registers
    always_ff @(posedge clk) begin
        if (Reset) begin
            we_q      <= 1'b0;
            ad3_q     <= '0;
            wd3_q     <= '0;
            pending_q <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
        end else begin
            we_q      <= we_d;
            ad3_q     <= ad3_d;
            wd3_q     <= wd3_d;
            pending_q <= pending_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
        end
    end

    // Queue storage
    always_ff @(posedge clk) begin
        if (Reset) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                q_rd_q[i]   <= '0;
                q_data_q[i] <= '0;
            end
        end else begin
            if (alu_enq_s) begin
                q_rd_q[tail_q]   <= alu_rd;
                q_data_q[tail_q] <= alu_data;
            end
            if (mem_enq_s) begin
                q_rd_q[mem_slot_s]   <= mem_rd;
                q_data_q[mem_slot_s] <= mem_data;
            end
        end
    end

    assign WE  = we_q;
    assign AD3 = ad3_q;
    assign WD3 = wd3_q;

    regfile_write_port_ctrl_chk #(
        .CNT_W     (CNT_W),
        .BUF_DEPTH (BUF_DEPTH)
    ) u_chk (
        .clk_i       (clk),
        .reset_i     (Reset),
        .alu_valid_i (alu_valid),
        .count_i     (count_q)
    );
endmodule

// File: tb/tb_regfile_write_port_ctrl.sv
// Directed bench for regfile_write_port_ctrl with hand-computed expectations (default BUF_DEPTH=4).
module tb_regfile_write_port_ctrl;
    logic        clk;
    logic        Reset;
    logic        issue_valid;
    logic [4:0]  issue_rd, issue_rs1, issue_rs2;
    logic        issue_ready;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        mem_valid;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic        mem_ready;
    logic        WE;
    logic [4:0]  AD3;
    logic [31:0] WD3;
`ifdef RF_FORWARD_EN
    logic        fwd1_hit, fwd2_hit;
    logic [31:0] fwd1_data, fwd2_data;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    regfile_write_port_ctrl dut (
        .clk         (clk),
        .Reset       (Reset),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .issue_rs1   (issue_rs1),
        .issue_rs2   (issue_rs2),
        .issue_ready (issue_ready),
        .alu_valid   (alu_valid),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .mem_valid   (mem_valid),
        .mem_rd      (mem_rd),
        .mem_data    (mem_data),
        .mem_ready   (mem_ready),
        .WE          (WE),
        .AD3         (AD3),
        .WD3         (WD3)
`ifdef RF_FORWARD_EN
        ,
        .fwd1_hit    (fwd1_hit),
        .fwd1_data   (fwd1_data),
        .fwd2_hit    (fwd2_hit),
        .fwd2_data   (fwd2_data)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Fill pattern: alu/mem destination per cycle and expected write order
    logic [4:0] fill_alu [3];
    logic [4:0] fill_mem [3];
    logic [4:0] fill_exp_ad3 [6];
    logic       fill_exp_rdy [3];

    initial begin
        fill_alu = '{5'd8, 5'd10, 5'd12};
        fill_mem = '{5'd9, 5'd11, 5'd13};
        fill_exp_ad3 = '{5'd8, 5'd9, 5'd10, 5'd11, 5'd12, 5'd13};
        fill_exp_rdy = '{1'b1, 1'b1, 1'b0};

        Reset = 1'b1; issue_valid = 1'b0; issue_rd = '0; issue_rs1 = '0; issue_rs2 = '0;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
        tick(); tick();
        check_val("reset_we", 32'(WE), 32'd0);
        check_val("reset_ad3", 32'(AD3), 32'd0);
        check_val("reset_wd3", WD3, 32'd0);
        check_val("reset_issue_ready", 32'(issue_ready), 32'd1);
        check_val("reset_mem_ready", 32'(mem_ready), 32'd1);

        // Single ALU write, one cycle latency
        Reset = 1'b0; alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h0000_00AA;
        tick();
        alu_valid = 1'b0;
        check_val("alu_we", 32'(WE), 32'd1);
        check_val("alu_ad3", 32'(AD3), 32'd5);
        check_val("alu_wd3", WD3, 32'h0000_00AA);
        tick();
        check_val("alu_we_drop", 32'(WE), 32'd0);
        check_val("alu_ad3_hold", 32'(AD3), 32'd5);
        check_val("alu_wd3_hold", WD3, 32'h0000_00AA);

        // RAW stall released by load writeback
        issue_valid = 1'b1; issue_rd = 5'd3; #1;
        check_val("raw_issue_rd3", 32'(issue_ready), 32'd1);
        tick();
        issue_rd = 5'd0; issue_rs1 = 5'd3; #1;
        check_val("raw_stall", 32'(issue_ready), 32'd0);
        mem_valid = 1'b1; mem_rd = 5'd3; mem_data = 32'h0000_1234;
        tick();
        mem_valid = 1'b0; #1;
        check_val("raw_mem_we", 32'(WE), 32'd1);
        check_val("raw_mem_ad3", 32'(AD3), 32'd3);
        check_val("raw_mem_wd3", WD3, 32'h0000_1234);
`ifdef RF_FORWARD_EN
        check_val("raw_fwd_ready", 32'(issue_ready), 32'd1);
        check_val("raw_fwd1_hit", 32'(fwd1_hit), 32'd1);
        check_val("raw_fwd1_data", fwd1_data, 32'h0000_1234);
`else
        check_val("raw_we_cycle_stall", 32'(issue_ready), 32'd0);
`endif
        tick();
        check_val("raw_released", 32'(issue_ready), 32'd1);
        issue_valid = 1'b0; issue_rs1 = 5'd0;

        // Simultaneous ALU and load with empty queue
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h11;
        mem_valid = 1'b1; mem_rd = 5'd2; mem_data = 32'h22; #1;
        check_val("dual_mem_ready_pre", 32'(mem_ready), 32'd1);
        tick();
        alu_valid = 1'b0; mem_valid = 1'b0; #1;
        check_val("dual_we1", 32'(WE), 32'd1);
        check_val("dual_ad3_1", 32'(AD3), 32'd1);
        check_val("dual_wd3_1", WD3, 32'h11);
        check_val("dual_mem_ready", 32'(mem_ready), 32'd1);
        tick();
        check_val("dual_we2", 32'(WE), 32'd1);
        check_val("dual_ad3_2", 32'(AD3), 32'd2);
        check_val("dual_wd3_2", WD3, 32'h22);
        tick();
        check_val("dual_idle", 32'(WE), 32'd0);

        // Sustained dual traffic fills the queue until backpressure
        for (int i = 0; i < 3; i++) begin
            alu_valid = 1'b1; alu_rd = fill_alu[i]; alu_data = 32'h100 + 32'(fill_alu[i]);
            mem_valid = 1'b1; mem_rd = fill_mem[i]; mem_data = 32'h100 + 32'(fill_mem[i]);
            tick();
            alu_valid = 1'b0; mem_valid = 1'b0; #1;
            check_val("fill_mem_ready", 32'(mem_ready), 32'(fill_exp_rdy[i]));
            check_val("fill_issue_ready", 32'(issue_ready), 32'(fill_exp_rdy[i]));
            check_val("fill_we", 32'(WE), 32'd1);
            check_val("fill_ad3", 32'(AD3), 32'(fill_exp_ad3[i]));
            check_val("fill_wd3", WD3, 32'h100 + 32'(fill_exp_ad3[i]));
        end
        for (int i = 3; i < 6; i++) begin
            tick();
            check_val("drain_we", 32'(WE), 32'd1);
            check_val("drain_ad3", 32'(AD3), 32'(fill_exp_ad3[i]));
            check_val("drain_wd3", WD3, 32'h100 + 32'(fill_exp_ad3[i]));
        end
        tick();
        check_val("drain_idle", 32'(WE), 32'd0);
        check_val("drain_mem_ready", 32'(mem_ready), 32'd1);

        // Writes and issues to x0 are dropped
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFF_FFFF;
        mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'hFFFF_FFFF;
        issue_valid = 1'b1; issue_rd = 5'd0;
        tick();
        alu_valid = 1'b0; mem_valid = 1'b0; #1;
        check_val("x0_we", 32'(WE), 32'd0);
        check_val("x0_issue_ready", 32'(issue_ready), 32'd1);
        tick();
        check_val("x0_we_next", 32'(WE), 32'd0);
        check_val("x0_mem_ready", 32'(mem_ready), 32'd1);

        // Mid-operation reset discards queue and scoreboard
        issue_rd = 5'd20;
        alu_valid = 1'b1; alu_rd = 5'd14; alu_data = 32'h14;
        mem_valid = 1'b1; mem_rd = 5'd15; mem_data = 32'h15;
        tick();
        issue_rd = 5'd21;
        alu_rd = 5'd16; alu_data = 32'h16; mem_rd = 5'd17; mem_data = 32'h17;
        tick();
        alu_valid = 1'b0; mem_valid = 1'b0;
        issue_rd = 5'd0; issue_rs1 = 5'd20; issue_rs2 = 5'd21; #1;
        check_val("pre_reset_stall", 32'(issue_ready), 32'd0);
        check_val("pre_reset_ad3", 32'(AD3), 32'd15);
        issue_valid = 1'b0;
        Reset = 1'b1;
        tick();
        Reset = 1'b0; issue_valid = 1'b1; #1;
        check_val("rst_we", 32'(WE), 32'd0);
        check_val("rst_ad3", 32'(AD3), 32'd0);
        check_val("rst_issue_ready", 32'(issue_ready), 32'd1);
        check_val("rst_mem_ready", 32'(mem_ready), 32'd1);
        issue_valid = 1'b0;
        tick();
        check_val("rst_queue_empty", 32'(WE), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
